// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds FSM/owner encodings, the word access mode and the captured issue request.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  mode;
    logic [31:0] wdata;
  } issue_req_t;

  localparam issue_req_t ISSUE_CLEAR = '{addr: 32'h0, wen: 1'b0, mode: 3'b000, wdata: 32'h0};

  // Fetches are always word-sized reads with no store data.
  function automatic issue_req_t fetch_issue(input logic [31:0] addr);
    issue_req_t req;
    req.addr  = addr;
    req.wen   = 1'b0;
    req.mode  = MODE_WORD;
    req.wdata = 32'h0;
    return req;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter.
// slave is the arbiter's view; master is the requesters plus the memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_wen;
  logic [2:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [2:0]  mem_sel;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;

  modport slave (
    input  if_req, if_addr, d_req, d_wen, d_mode, d_addr, d_wdata, mem_data_o,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wen, mem_sel, mem_data_i
  );

  modport master (
    output if_req, if_addr, d_req, d_wen, d_mode, d_addr, d_wdata, mem_data_o,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wen, mem_sel, mem_data_i
  );
endinterface

// File: rtl/mem_arbiter_arb_prio_starve.sv
// Data-priority grant logic with a starvation counter that forces a fetch
// grant after STARVE_MAX consecutive data grants taken while fetch was waiting.
module arb_prio_starve #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_s;

  // Grant selection and next starvation count.
  always_comb begin
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    starve_cnt_s = starve_cnt_r;
    if (arb_en) begin
      if (d_req && if_req) begin
        if (starve_cnt_r < STARVE_LIM) begin
          d_gnt        = 1'b1;
          starve_cnt_s = starve_cnt_r + 4'd1;
        end else begin
          if_gnt       = 1'b1;
          starve_cnt_s = 4'd0;
        end
      end else if (d_req) begin
        d_gnt        = 1'b1;
        starve_cnt_s = 4'd0;
      end else if (if_req) begin
        if_gnt       = 1'b1;
        starve_cnt_s = 4'd0;
      end else begin
        starve_cnt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter sharing one fixed-latency memory port between
// instruction fetch and data load/store, with data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  state_e      state_r;
  state_e      state_s;
  owner_e      owner_r;
  logic [2:0]  lat_cnt_r;
  issue_req_t  issue_r;
  issue_req_t  issue_s;
  logic        mem_wen_r;
  logic [31:0] if_rdata_r;
  logic [31:0] d_rdata_r;
  logic        arb_en_s;
  logic        if_gnt_s;
  logic        d_gnt_s;
  logic        grant_s;
  logic        if_rvalid_s;
  logic        d_rvalid_s;
  logic [31:0] resp_data_s;

  // Grants are suppressed while reset is held so every output reads 0.
  assign arb_en_s = (state_r == IDLE) && rst;
  assign grant_s  = if_gnt_s || d_gnt_s;

  arb_prio_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .arb_en(arb_en_s),
    .if_req(bus.if_req),
    .d_req (bus.d_req),
    .if_gnt(if_gnt_s),
    .d_gnt (d_gnt_s)
  );

  // Next state and response pulse generation.
  always_comb begin
    state_s     = state_r;
    if_rvalid_s = 1'b0;
    d_rvalid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (lat_cnt_r == 3'd1) begin
          state_s = IDLE;
          if (!rst) begin
            if_rvalid_s = 1'b0;
            d_rvalid_s  = 1'b0;
          end else if (owner_r == OWN_IF) begin
            if_rvalid_s = 1'b1;
          end else begin
            d_rvalid_s = 1'b1;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Issue request to capture on a grant.
  always_comb begin
    issue_s = issue_r;
    if (d_gnt_s) begin
      issue_s = '{addr: bus.d_addr, wen: bus.d_wen, mode: bus.d_mode, wdata: bus.d_wdata};
    end else if (if_gnt_s) begin
      issue_s = fetch_issue(bus.if_addr);
    end else begin
      issue_s = issue_r;
    end
  end

  assign resp_data_s = issue_r.wen ? 32'h0 : bus.mem_data_o;

  // Transaction state, issue registers and held response data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      owner_r    <= OWN_IF;
      lat_cnt_r  <= 3'd0;
      issue_r    <= ISSUE_CLEAR;
      mem_wen_r  <= 1'b0;
      if_rdata_r <= 32'h0;
      d_rdata_r  <= 32'h0;
    end else begin
      state_r   <= state_s;
      issue_r   <= issue_s;
      mem_wen_r <= grant_s && issue_s.wen;
      if (d_gnt_s) begin
        owner_r <= OWN_D;
      end else if (if_gnt_s) begin
        owner_r <= OWN_IF;
      end else begin
        owner_r <= owner_r;
      end
      if (grant_s) begin
        lat_cnt_r <= LAT_LOAD;
      end else if (state_r == BUSY) begin
        lat_cnt_r <= lat_cnt_r - 3'd1;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
      if (if_rvalid_s) begin
        if_rdata_r <= resp_data_s;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (d_rvalid_s) begin
        d_rdata_r <= resp_data_s;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  // The response word is visible in the rvalid cycle itself, then held.
  assign bus.if_gnt     = if_gnt_s;
  assign bus.d_gnt      = d_gnt_s;
  assign bus.if_rvalid  = if_rvalid_s;
  assign bus.d_rvalid   = d_rvalid_s;
  assign bus.if_rdata   = if_rvalid_s ? resp_data_s : if_rdata_r;
  assign bus.d_rdata    = d_rvalid_s ? resp_data_s : d_rdata_r;
  assign bus.mem_addr   = issue_r.addr;
  assign bus.mem_sel    = issue_r.mode;
  assign bus.mem_data_i = issue_r.wdata;
  assign bus.mem_wen    = mem_wen_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (MEM_LAT 1,2,3) share one stimulus;
// a directed table, corner-case sequences and a randomized transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_wen;
  logic [2:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_data;

  logic        o_if_gnt  [3];
  logic        o_d_gnt   [3];
  logic        o_if_rv   [3];
  logic        o_d_rv    [3];
  logic [31:0] o_if_rd   [3];
  logic [31:0] o_d_rd    [3];
  logic [31:0] o_addr    [3];
  logic        o_wen     [3];
  logic [2:0]  o_sel     [3];
  logic [31:0] o_wdat    [3];

  int checks = 0;
  int failures = 0;
  int cur = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter_if bus ();
    assign bus.if_req     = if_req;
    assign bus.if_addr    = if_addr;
    assign bus.d_req      = d_req;
    assign bus.d_wen      = d_wen;
    assign bus.d_mode     = d_mode;
    assign bus.d_addr     = d_addr;
    assign bus.d_wdata    = d_wdata;
    assign bus.mem_data_o = mem_data;
    mem_arbiter #(.MEM_LAT(g + 1), .STARVE_MAX(STARVE)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign o_if_gnt[g] = bus.if_gnt;
    assign o_d_gnt[g]  = bus.d_gnt;
    assign o_if_rv[g]  = bus.if_rvalid;
    assign o_d_rv[g]   = bus.d_rvalid;
    assign o_if_rd[g]  = bus.if_rdata;
    assign o_d_rd[g]   = bus.d_rdata;
    assign o_addr[g]   = bus.mem_addr;
    assign o_wen[g]    = bus.mem_wen;
    assign o_sel[g]    = bus.mem_sel;
    assign o_wdat[g]   = bus.mem_data_i;
  end

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwen;
    logic [2:0]  dmode;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [2:0]  e_sel;
    logic [31:0] e_wdat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (dut lat %0d) got=%h want=%h at %0t", nm, cur + 1, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_wen = 1'b0;
    d_mode = 3'b000; d_addr = 32'h0; d_wdata = 32'h0; mem_data = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_if_gnt"}, 32'(o_if_gnt[cur]), 32'h0);
    chk({nm, "_d_gnt"}, 32'(o_d_gnt[cur]), 32'h0);
    chk({nm, "_if_rv"}, 32'(o_if_rv[cur]), 32'h0);
    chk({nm, "_d_rv"}, 32'(o_d_rv[cur]), 32'h0);
    chk({nm, "_if_rd"}, o_if_rd[cur], 32'h0);
    chk({nm, "_d_rd"}, o_d_rd[cur], 32'h0);
    chk({nm, "_addr"}, o_addr[cur], 32'h0);
    chk({nm, "_wen"}, 32'(o_wen[cur]), 32'h0);
    chk({nm, "_sel"}, 32'(o_sel[cur]), 32'h0);
    chk({nm, "_wdat"}, o_wdat[cur], 32'h0);
  endtask

  // Transaction-level reference state for the random phase.
  int          t, free_at, resp_at, wen_at, starve, lat;
  logic        resp_d, resp_wen, e_ig, e_dg, e_irv, e_drv, e_wen;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [2:0]  m_sel;
  logic        i_pend, d_pend, p_dwen;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic [2:0]  p_dmode;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00500093,
                1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 32'h0, 32'h100, 1'b0, 3'b010, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h2003, 32'hAB, 32'h11111111,
                1'b0, 1'b1, 1'b0, 32'h00500093, 1'b0, 32'h0, 32'h100, 1'b0, 3'b010, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h22222222,
                1'b0, 1'b0, 1'b0, 32'h00500093, 1'b1, 32'h0, 32'h2003, 1'b1, 3'b000, 32'hAB};
    vecs[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h33333333,
                1'b0, 1'b0, 1'b0, 32'h00500093, 1'b0, 32'h0, 32'h2003, 1'b0, 3'b000, 32'hAB};
    vecs[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 3'b101, 32'h3000, 32'h55, 32'h0,
                1'b0, 1'b1, 1'b0, 32'h00500093, 1'b0, 32'h0, 32'h2003, 1'b0, 3'b000, 32'hAB};
    vecs[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFEF00D,
                1'b0, 1'b0, 1'b0, 32'h00500093, 1'b1, 32'hCAFEF00D, 32'h3000, 1'b0, 3'b101, 32'h55};
    vecs[8] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h00500093, 1'b0, 32'hCAFEF00D, 32'h3000, 1'b0, 3'b101, 32'h55};

    // Directed table on MEM_LAT=1: reset, lone fetch, lone store, load.
    cur = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
      d_req = vecs[i].dreq; d_wen = vecs[i].dwen; d_mode = vecs[i].dmode;
      d_addr = vecs[i].daddr; d_wdata = vecs[i].dwdata; mem_data = vecs[i].mdata;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 32'(o_if_gnt[cur]), 32'(vecs[i].e_igt));
      chk($sformatf("v%0d_d_gnt", i), 32'(o_d_gnt[cur]), 32'(vecs[i].e_dgt));
      chk($sformatf("v%0d_if_rv", i), 32'(o_if_rv[cur]), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_if_rd", i), o_if_rd[cur], vecs[i].e_ird);
      chk($sformatf("v%0d_d_rv", i), 32'(o_d_rv[cur]), 32'(vecs[i].e_drv));
      chk($sformatf("v%0d_d_rd", i), o_d_rd[cur], vecs[i].e_drd);
      chk($sformatf("v%0d_addr", i), o_addr[cur], vecs[i].e_addr);
      chk($sformatf("v%0d_wen", i), 32'(o_wen[cur]), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_sel", i), 32'(o_sel[cur]), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_wdat", i), o_wdat[cur], vecs[i].e_wdat);
      tick();
    end

    // Both requesters held: D,D,D,D,IF,D,D,D,D,IF.
    cur = 0;
    do_reset();
    begin
      int n;
      n = 0;
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h8000;
      for (int c = 0; c < 40 && n < 10; c++) begin
        mem_data = $urandom;
        @(negedge clk);
        if (o_if_gnt[cur] || o_d_gnt[cur]) begin
          chk("dual_gnt", 32'(o_if_gnt[cur] && o_d_gnt[cur]), 32'h0);
          chk($sformatf("order_%0d_is_if", n), 32'(o_if_gnt[cur]), 32'((n == 4) || (n == 9)));
          n++;
        end
        tick();
      end
      chk("grant_count", 32'(n), 32'd10);
    end

    // MEM_LAT=3 load and a request that must wait for the response.
    cur = 2;
    do_reset();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h4000; d_mode = 3'b010;
    @(negedge clk);
    chk("lat3_gnt0", 32'(o_d_gnt[cur]), 32'h1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      d_req = 1'b1; d_addr = 32'h5000;
      mem_data = (c == 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      chk($sformatf("lat3_rv_c%0d", c), 32'(o_d_rv[cur]), 32'(c == 3));
      chk($sformatf("lat3_gnt_c%0d", c), 32'(o_d_gnt[cur]), 32'(c == 4));
      if (c == 3) chk("lat3_rdata", o_d_rd[cur], 32'hDEADBEEF);
      tick();
    end

    // Reset during the last BUSY cycle of a MEM_LAT=2 store.
    cur = 1;
    do_reset();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h6000; d_wdata = 32'h77; if_req = 1'b1; if_addr = 32'h180;
    @(negedge clk);
    chk("rmid_d_gnt", 32'(o_d_gnt[cur]), 32'h1);
    chk("rmid_if_gnt0", 32'(o_if_gnt[cur]), 32'h0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("rmid_wen", 32'(o_wen[cur]), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_no_rv", 32'(o_d_rv[cur]), 32'h0);
    tick();
    @(negedge clk);
    chk_all_zero("rmid_zero");
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_if_gnt", 32'(o_if_gnt[cur]), 32'h1);
    chk("rmid_no_rv2", 32'(o_d_rv[cur]), 32'h0);
    tick();
    if_req = 1'b0;

    // Requester fields change after the grant on MEM_LAT=3.
    cur = 2;
    do_reset();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h7000; d_wdata = 32'h99; d_mode = 3'b001;
    @(negedge clk);
    chk("drop_gnt", 32'(o_d_gnt[cur]), 32'h1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      d_req = 1'b0; d_addr = 32'hFFFF0000; d_wen = 1'b0; d_wdata = 32'h0; d_mode = 3'b111;
      @(negedge clk);
      chk($sformatf("drop_addr_c%0d", c), o_addr[cur], 32'h7000);
      chk($sformatf("drop_wen_c%0d", c), 32'(o_wen[cur]), 32'(c == 1));
      chk($sformatf("drop_sel_c%0d", c), 32'(o_sel[cur]), 32'h1);
      chk($sformatf("drop_wdat_c%0d", c), o_wdat[cur], 32'h99);
      if (c == 3) chk("drop_rv", 32'(o_d_rv[cur]), 32'h1);
      tick();
    end

    // Random traffic against the transaction-level model, every latency.
    for (int k = 0; k < 3; k++) begin
      cur = k;
      lat = k + 1;
      do_reset();
      t = 0; free_at = 0; resp_at = -1; wen_at = -1; starve = 0;
      resp_d = 1'b0; resp_wen = 1'b0;
      m_addr = 32'h0; m_wdata = 32'h0; m_sel = 3'b000; m_ird = 32'h0; m_drd = 32'h0;
      i_pend = 1'b0; d_pend = 1'b0;
      p_iaddr = 32'h0; p_daddr = 32'h0; p_dwdata = 32'h0; p_dmode = 3'b000; p_dwen = 1'b0;
      for (int c = 0; c < 250; c++) begin
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          i_pend = 1'b1; p_iaddr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 1) == 0) begin
          d_pend = 1'b1; p_daddr = $urandom; p_dwdata = $urandom;
          p_dwen = 1'($urandom_range(0, 1)); p_dmode = 3'($urandom_range(0, 7));
        end
        if_req = i_pend; if_addr = i_pend ? p_iaddr : $urandom;
        d_req = d_pend; d_addr = d_pend ? p_daddr : $urandom;
        d_wdata = d_pend ? p_dwdata : $urandom;
        d_wen = d_pend ? p_dwen : 1'($urandom_range(0, 1));
        d_mode = d_pend ? p_dmode : 3'($urandom_range(0, 7));
        mem_data = $urandom;
        @(negedge clk);
        e_ig = 1'b0; e_dg = 1'b0;
        if (t >= free_at) begin
          if (d_pend && (!i_pend || starve < STARVE)) e_dg = 1'b1;
          else if (i_pend) e_ig = 1'b1;
        end
        e_irv = (t == resp_at) && !resp_d;
        e_drv = (t == resp_at) && resp_d;
        if (e_irv) m_ird = mem_data;
        if (e_drv) m_drd = resp_wen ? 32'h0 : mem_data;
        e_wen = (t == wen_at);
        chk("rnd_if_gnt", 32'(o_if_gnt[cur]), 32'(e_ig));
        chk("rnd_d_gnt", 32'(o_d_gnt[cur]), 32'(e_dg));
        chk("rnd_if_rv", 32'(o_if_rv[cur]), 32'(e_irv));
        chk("rnd_d_rv", 32'(o_d_rv[cur]), 32'(e_drv));
        chk("rnd_if_rd", o_if_rd[cur], m_ird);
        chk("rnd_d_rd", o_d_rd[cur], m_drd);
        chk("rnd_addr", o_addr[cur], m_addr);
        chk("rnd_wen", 32'(o_wen[cur]), 32'(e_wen));
        chk("rnd_sel", 32'(o_sel[cur]), 32'(m_sel));
        chk("rnd_wdat", o_wdat[cur], m_wdata);
        if (e_dg) begin
          starve = i_pend ? starve + 1 : 0;
          m_addr = p_daddr; m_sel = p_dmode; m_wdata = p_dwdata;
          resp_at = t + lat; free_at = t + lat + 1; wen_at = p_dwen ? t + 1 : -1;
          resp_d = 1'b1; resp_wen = p_dwen; d_pend = 1'b0;
        end else if (e_ig) begin
          starve = 0;
          m_addr = p_iaddr; m_sel = 3'b010; m_wdata = 32'h0;
          resp_at = t + lat; free_at = t + lat + 1; wen_at = -1;
          resp_d = 1'b0; resp_wen = 1'b0; i_pend = 1'b0;
        end
        t++;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
